axi_stream_protocol_checker: RTL and testbench

- Synthesizable, multi-channel runtime checker for AXI4-Stream links (AXI4-Stream v1.0 Issue A).
- Passively taps NUM_CHANNELS independent streams and flags handshake and payload violations in sticky per-channel error registers.
- Adds stall-timeout and packet-length watchdogs, plus saturating beat and packet counters.
- Sits beside the bus in silicon or FPGA builds, where formal properties are unavailable. Never drives the bus.

---
 rtl/axi_stream_checker_pkg.sv | 16 +
 rtl/axi_stream_channel_checker.sv | 119 +++++++++++
 rtl/axi_stream_protocol_checker.sv | 80 ++++++++
 tb/tb_axi_stream_protocol_checker.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_checker_pkg.sv
// Shared constants for the AXI4-Stream protocol checker: error bit layout and a width helper.
package axi_stream_checker_pkg;

    localparam int ERR_VALID_DROP     = 0;
    localparam int ERR_PAYLOAD_CHANGE = 1;
    localparam int ERR_STRB_NO_KEEP   = 2;
    localparam int ERR_STALL_TIMEOUT  = 3;
    localparam int ERR_PKT_TOO_LONG   = 4;
    localparam int ERR_BITS           = 5;

    // Optional sideband fields of width 0 still occupy one (ignored) port bit.
    function automatic int max1(input int w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/axi_stream_channel_checker.sv
// Passive monitor for one AXI4-Stream channel: sticky handshake/payload errors,
// stall and packet-length watchdogs, packet tracking and saturating statistics.
module axi_stream_channel_checker
    import axi_stream_checker_pkg::*;
#(
    parameter int BYTE_WIDTH    = 4,
    parameter int ID_WIDTH      = 0,
    parameter int DEST_WIDTH    = 0,
    parameter int USER_WIDTH    = 0,
    parameter int CNT_WIDTH     = 32,
    parameter int STALL_LIMIT   = 1024,
    parameter int MAX_PKT_BEATS = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tvalid,
    input  logic                        tready,
    input  logic [8*BYTE_WIDTH-1:0]     tdata,
    input  logic [BYTE_WIDTH-1:0]       tstrb,
    input  logic [BYTE_WIDTH-1:0]       tkeep,
    input  logic                        tlast,
    input  logic [max1(ID_WIDTH)-1:0]   tid,
    input  logic [max1(DEST_WIDTH)-1:0] tdest,
    input  logic [max1(USER_WIDTH)-1:0] tuser,
    input  logic                        err_clear,
    output logic [ERR_BITS-1:0]         err_flags,
    output logic                        in_packet,
    output logic [CNT_WIDTH-1:0]        beat_count,
    output logic [CNT_WIDTH-1:0]        pkt_count
);

    localparam int IW = max1(ID_WIDTH);
    localparam int DW = max1(DEST_WIDTH);
    localparam int UW = max1(USER_WIDTH);
    localparam int PW = 8*BYTE_WIDTH + 2*BYTE_WIDTH + 1 + IW + DW + UW;
    localparam int SW = max1($clog2(STALL_LIMIT + 1));
    localparam int LW = max1($clog2(MAX_PKT_BEATS + 1));

    localparam logic [SW-1:0] STALL_MAX  = SW'(STALL_LIMIT);
    localparam logic [SW-1:0] STALL_TRIG = SW'((STALL_LIMIT == 0) ? 0 : STALL_LIMIT - 1);
    localparam logic [LW-1:0] PKT_MAX    = LW'(MAX_PKT_BEATS);
    localparam logic [LW-1:0] PKT_TRIG   = LW'((MAX_PKT_BEATS == 0) ? 0 : MAX_PKT_BEATS - 1);

    logic          hs;
    logic          stalled;
    logic [IW-1:0] tid_m;
    logic [DW-1:0] tdest_m;
    logic [UW-1:0] tuser_m;
    logic [PW-1:0] payload;

    logic          prev_valid;
    logic          prev_ready;
    logic [PW-1:0] prev_payload;
    logic [SW-1:0] stall_cnt;
    logic [LW-1:0] pkt_len;
    logic [ERR_BITS-1:0] err_set;

    assign hs      = tvalid && tready;
    assign stalled = tvalid && !tready;

    // Absent sideband fields are forced to zero so they never affect the compare.
    assign tid_m   = (ID_WIDTH   > 0) ? tid   : '0;
    assign tdest_m = (DEST_WIDTH > 0) ? tdest : '0;
    assign tuser_m = (USER_WIDTH > 0) ? tuser : '0;
    assign payload = {tdata, tstrb, tkeep, tlast, tid_m, tdest_m, tuser_m};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        err_set = '0;
        err_set[ERR_VALID_DROP]     = prev_valid && !prev_ready && !tvalid;
        err_set[ERR_PAYLOAD_CHANGE] = prev_valid && !prev_ready && tvalid && (payload != prev_payload);
        err_set[ERR_STRB_NO_KEEP]   = tvalid && |(tstrb & ~tkeep);
        err_set[ERR_STALL_TIMEOUT]  = (STALL_LIMIT != 0) && stalled && (stall_cnt == STALL_TRIG);
        err_set[ERR_PKT_TOO_LONG]   = (MAX_PKT_BEATS != 0) && hs && !tlast && (pkt_len == PKT_TRIG);
    end

    // NOTE: all state is plain flops (no memories), so every bit is cleared by the async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_valid   <= 1'b0;
            prev_ready   <= 1'b0;
            prev_payload <= '0;
            stall_cnt    <= '0;
            pkt_len      <= '0;
            err_flags    <= '0;
            in_packet    <= 1'b0;
            beat_count   <= '0;
            pkt_count    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
            prev_valid   <= tvalid;
            prev_ready   <= tready;
            prev_payload <= payload;

            // A new violation wins over a same-cycle clear.
            err_flags <= (err_flags & ~{ERR_BITS{err_clear}}) | err_set;

            if ((STALL_LIMIT != 0) && stalled) begin
                if (stall_cnt != STALL_MAX)
                    stall_cnt <= stall_cnt + SW'(1);
            end else begin
                stall_cnt <= '0;
            end

            if (hs) begin
                if (tlast)
                    pkt_len <= '0;
                else if ((MAX_PKT_BEATS != 0) && (pkt_len != PKT_MAX))
                    pkt_len <= pkt_len + LW'(1);
                in_packet <= !tlast;
                if (beat_count != '1)
                    beat_count <= beat_count + CNT_WIDTH'(1);
                if (tlast && (pkt_count != '1))
                    pkt_count <= pkt_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/axi_stream_protocol_checker.sv
// Multi-channel AXI4-Stream runtime checker: slices the flattened tap buses into
// per-channel monitors and registers the OR of all sticky error flags.
module axi_stream_protocol_checker
    import axi_stream_checker_pkg::*;
#(
    parameter int NUM_CHANNELS  = 2,
    parameter int BYTE_WIDTH    = 4,
    parameter int ID_WIDTH      = 0,
    parameter int DEST_WIDTH    = 0,
    parameter int USER_WIDTH    = 0,
    parameter int CNT_WIDTH     = 32,
    parameter int STALL_LIMIT   = 1024,
    parameter int MAX_PKT_BEATS = 0
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CHANNELS-1:0]                  tvalid,
    input  logic [NUM_CHANNELS-1:0]                  tready,
    input  logic [NUM_CHANNELS*8*BYTE_WIDTH-1:0]     tdata,
    input  logic [NUM_CHANNELS*BYTE_WIDTH-1:0]       tstrb,
    input  logic [NUM_CHANNELS*BYTE_WIDTH-1:0]       tkeep,
    input  logic [NUM_CHANNELS-1:0]                  tlast,
    input  logic [NUM_CHANNELS*max1(ID_WIDTH)-1:0]   tid,
    input  logic [NUM_CHANNELS*max1(DEST_WIDTH)-1:0] tdest,
    input  logic [NUM_CHANNELS*max1(USER_WIDTH)-1:0] tuser,
    input  logic [NUM_CHANNELS-1:0]                  err_clear,
    output logic [NUM_CHANNELS*ERR_BITS-1:0]         err_flags,
    output logic                                     err_any,
    output logic [NUM_CHANNELS-1:0]                  in_packet,
    output logic [NUM_CHANNELS*CNT_WIDTH-1:0]        beat_count,
    output logic [NUM_CHANNELS*CNT_WIDTH-1:0]        pkt_count
);

    localparam int DBITS = 8*BYTE_WIDTH;
    localparam int IW    = max1(ID_WIDTH);
    localparam int DW    = max1(DEST_WIDTH);
    localparam int UW    = max1(USER_WIDTH);

    if (NUM_CHANNELS < 1 || BYTE_WIDTH < 1 || CNT_WIDTH < 1 ||
        STALL_LIMIT < 0 || MAX_PKT_BEATS < 0) begin : g_bad_params
        $error("axi_stream_protocol_checker: illegal parameter set");
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        axi_stream_channel_checker #(
            .BYTE_WIDTH    (BYTE_WIDTH),
            .ID_WIDTH      (ID_WIDTH),
            .DEST_WIDTH    (DEST_WIDTH),
            .USER_WIDTH    (USER_WIDTH),
            .CNT_WIDTH     (CNT_WIDTH),
            .STALL_LIMIT   (STALL_LIMIT),
            .MAX_PKT_BEATS (MAX_PKT_BEATS)
        ) u_chk (
            .clk        (clk),
            .reset      (reset),
            .tvalid     (tvalid[c]),
            .tready     (tready[c]),
            .tdata      (tdata[c*DBITS +: DBITS]),
            .tstrb      (tstrb[c*BYTE_WIDTH +: BYTE_WIDTH]),
            .tkeep      (tkeep[c*BYTE_WIDTH +: BYTE_WIDTH]),
            .tlast      (tlast[c]),
            .tid        (tid[c*IW +: IW]),
            .tdest      (tdest[c*DW +: DW]),
            .tuser      (tuser[c*UW +: UW]),
            .err_clear  (err_clear[c]),
            .err_flags  (err_flags[c*ERR_BITS +: ERR_BITS]),
            .in_packet  (in_packet[c]),
            .beat_count (beat_count[c*CNT_WIDTH +: CNT_WIDTH]),
            .pkt_count  (pkt_count[c*CNT_WIDTH +: CNT_WIDTH])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_any <= 1'b0;
        else
            err_any <= |err_flags;
    end

endmodule

// File: tb/tb_axi_stream_protocol_checker.sv
// Directed self-checking bench for axi_stream_protocol_checker (2 channels, 4-byte data).
module tb_axi_stream_protocol_checker;

    localparam int NC = 2;
    localparam int BW = 4;
    localparam int CW = 8;
    localparam int SCW = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NC-1:0]     tvalid = '0;
    logic [NC-1:0]     tready = '0;
    logic [NC*32-1:0]  tdata = '0;
    logic [NC*BW-1:0]  tstrb = '0;
    logic [NC*BW-1:0]  tkeep = '0;
    logic [NC-1:0]     tlast = '0;
    logic [NC-1:0]     tid = '0;
    logic [NC-1:0]     tdest = '0;
    logic [NC-1:0]     tuser = '0;
    logic [NC-1:0]     err_clear = '0;

    logic [NC*5-1:0]   err_flags;
    logic              err_any;
    logic [NC-1:0]     in_packet;
    logic [NC*CW-1:0]  beat_count;
    logic [NC*CW-1:0]  pkt_count;

    logic [NC*5-1:0]   s_err_flags;
    logic              s_err_any;
    logic [NC-1:0]     s_in_packet;
    logic [NC*SCW-1:0] s_beat_count;
    logic [NC*SCW-1:0] s_pkt_count;

    int checks = 0;
    int errors = 0;

    axi_stream_protocol_checker #(
        .NUM_CHANNELS(NC), .BYTE_WIDTH(BW), .CNT_WIDTH(CW),
        .STALL_LIMIT(8), .MAX_PKT_BEATS(4)
    ) dut (
        .clk(clk), .reset(reset), .tvalid(tvalid), .tready(tready), .tdata(tdata),
        .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast), .tid(tid), .tdest(tdest),
        .tuser(tuser), .err_clear(err_clear), .err_flags(err_flags), .err_any(err_any),
        .in_packet(in_packet), .beat_count(beat_count), .pkt_count(pkt_count)
    );

    axi_stream_protocol_checker #(
        .NUM_CHANNELS(NC), .BYTE_WIDTH(BW), .CNT_WIDTH(SCW),
        .STALL_LIMIT(8), .MAX_PKT_BEATS(4)
    ) dut_sat (
        .clk(clk), .reset(reset), .tvalid(tvalid), .tready(tready), .tdata(tdata),
        .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast), .tid(tid), .tdest(tdest),
        .tuser(tuser), .err_clear(err_clear), .err_flags(s_err_flags), .err_any(s_err_any),
        .in_packet(s_in_packet), .beat_count(s_beat_count), .pkt_count(s_pkt_count)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] flags(input int ch);
        return err_flags[ch*5 +: 5];
    endfunction

    function automatic logic [CW-1:0] beats(input int ch);
        return beat_count[ch*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] pkts(input int ch);
        return pkt_count[ch*CW +: CW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input logic v, input logic r, input logic [31:0] d,
                         input logic [3:0] s, input logic [3:0] k, input logic l);
        tvalid[ch]           = v;
        tready[ch]           = r;
        tdata[ch*32 +: 32]   = d;
        tstrb[ch*BW +: BW]   = s;
        tkeep[ch*BW +: BW]   = k;
        tlast[ch]            = l;
    endtask

    task automatic idle_all();
        for (int c = 0; c < NC; c++) drive(c, 1'b0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);
        err_clear = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_all();
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        #5;
        checks++;
        if (err_flags !== '0 || err_any !== 1'b0 || in_packet !== '0 ||
            beat_count !== '0 || pkt_count !== '0) begin
            errors++;
            $display("FAIL reset_state: flags=%h any=%b inpkt=%b beats=%h pkts=%h, required all 0",
                     err_flags, err_any, in_packet, beat_count, pkt_count);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_legal_traffic();
        logic [31:0] d;
        for (int b = 0; b < 12; b++) begin
            d = 32'h1000_0000 + 32'(b);
            drive(0, 1'b1, 1'b0, d, 4'hF, 4'hF, (b % 4) == 3);
            step();
            drive(0, 1'b1, 1'b1, d, 4'hF, 4'hF, (b % 4) == 3);
            step();
            if (b == 0) begin
                checks++;
                if (in_packet[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL legal_in_packet_first: got %b required 1", in_packet[0]);
                end
            end
        end
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);
        step();
        checks++;
        if (flags(0) !== 5'b0 || err_any !== 1'b0) begin
            errors++;
            $display("FAIL legal_flags: got %b any=%b required 00000 any=0", flags(0), err_any);
        end
        checks++;
        if (beats(0) !== 8'd12 || pkts(0) !== 8'd3) begin
            errors++;
            $display("FAIL legal_counts: beats=%0d pkts=%0d required 12 3", beats(0), pkts(0));
        end
        checks++;
        if (in_packet[0] !== 1'b0) begin
            errors++;
            $display("FAIL legal_in_packet_end: got %b required 0", in_packet[0]);
        end
    endtask

    task automatic test_valid_drop();
        drive(1, 1'b1, 1'b0, 32'hCAFE_0001, 4'hF, 4'hF, 1'b1);
        step();
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);
        step();
        checks++;
        if (flags(1) !== 5'b00001 || err_any !== 1'b0) begin
            errors++;
            $display("FAIL valid_drop_set: ch1=%b any=%b required 00001 any=0", flags(1), err_any);
        end
        checks++;
        if (flags(0) !== 5'b0) begin
            errors++;
            $display("FAIL valid_drop_isolation: ch0=%b required 00000", flags(0));
        end
        step();
        checks++;
        if (err_any !== 1'b1) begin
            errors++;
            $display("FAIL valid_drop_err_any: got %b required 1", err_any);
        end
        err_clear[1] = 1'b1;
        step();
        err_clear[1] = 1'b0;
        checks++;
        if (flags(1) !== 5'b0) begin
            errors++;
            $display("FAIL valid_drop_clear: ch1=%b required 00000", flags(1));
        end
        step();
        checks++;
        if (err_any !== 1'b0) begin
            errors++;
            $display("FAIL valid_drop_err_any_clear: got %b required 0", err_any);
        end
    endtask

    task automatic test_payload_errors();
        drive(0, 1'b1, 1'b0, 32'hA5A5_A5A5, 4'hF, 4'hF, 1'b1);
        step();
        drive(0, 1'b1, 1'b0, 32'h5A5A_5A5A, 4'hF, 4'hF, 1'b1);
        step();
        checks++;
        if (flags(0) !== 5'b00010) begin
            errors++;
            $display("FAIL payload_change: ch0=%b required 00010", flags(0));
        end
        drive(0, 1'b1, 1'b1, 32'h5A5A_5A5A, 4'hF, 4'hF, 1'b1);
        step();
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);
        err_clear[0] = 1'b1;
        step();
        err_clear[0] = 1'b0;
        checks++;
        if (flags(0) !== 5'b0) begin
            errors++;
            $display("FAIL payload_change_clear: ch0=%b required 00000", flags(0));
        end
        drive(0, 1'b1, 1'b1, 32'h1234_5678, 4'b0011, 4'b0001, 1'b1);
        step();
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);
        checks++;
        if (flags(0) !== 5'b00100) begin
            errors++;
            $display("FAIL strb_no_keep: ch0=%b required 00100", flags(0));
        end
        err_clear[0] = 1'b1;
        step();
        err_clear[0] = 1'b0;
    endtask

    task automatic test_stall_timeout();
        logic [31:0] d = 32'hDEAD_BEEF;
        for (int i = 1; i <= 20; i++) begin
            drive(0, 1'b1, 1'b0, d, 4'hF, 4'hF, 1'b1);
            err_clear[0] = (i == 12);
            step();
            err_clear[0] = 1'b0;
            if (i == 7 || i == 12 || i == 20) begin
                checks++;
                if (flags(0) !== 5'b0) begin
                    errors++;
                    $display("FAIL stall_quiet_%0d: ch0=%b required 00000", i, flags(0));
                end
            end
            if (i == 8) begin
                checks++;
                if (flags(0) !== 5'b01000) begin
                    errors++;
                    $display("FAIL stall_fire: ch0=%b required 01000", flags(0));
                end
            end
        end
        drive(0, 1'b1, 1'b1, d, 4'hF, 4'hF, 1'b1);
        step();
        for (int i = 1; i <= 8; i++) begin
            drive(0, 1'b1, 1'b0, d, 4'hF, 4'hF, 1'b1);
            step();
        end
        checks++;
        if (flags(0) !== 5'b01000) begin
            errors++;
            $display("FAIL stall_refire: ch0=%b required 01000", flags(0));
        end
        drive(0, 1'b1, 1'b1, d, 4'hF, 4'hF, 1'b1);
        step();
        drive(0, 1'b1, 1'b0, d, 4'hF, 4'hF, 1'b1);
        err_clear[0] = 1'b1;
        step();
        err_clear[0] = 1'b0;
        checks++;
        if (flags(0) !== 5'b0) begin
            errors++;
            $display("FAIL stall_clear_on_start: ch0=%b required 00000", flags(0));
        end
        for (int i = 2; i <= 7; i++) step();
        checks++;
        if (flags(0) !== 5'b0) begin
            errors++;
            $display("FAIL stall_early_7: ch0=%b required 00000", flags(0));
        end
        step();
        checks++;
        if (flags(0) !== 5'b01000) begin
            errors++;
            $display("FAIL stall_new_8: ch0=%b required 01000", flags(0));
        end
        drive(0, 1'b1, 1'b1, d, 4'hF, 4'hF, 1'b1);
        step();
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);
        err_clear[0] = 1'b1;
        step();
        err_clear[0] = 1'b0;
    endtask

    task automatic test_pkt_too_long();
        do_reset();
        for (int b = 1; b <= 6; b++) begin
            drive(0, 1'b1, 1'b1, 32'h0000_0100 + 32'(b), 4'hF, 4'hF, 1'b0);
            step();
            if (b == 3) begin
                checks++;
                if (flags(0) !== 5'b0) begin
                    errors++;
                    $display("FAIL pkt_len_3: ch0=%b required 00000", flags(0));
                end
            end
            if (b == 4) begin
                checks++;
                if (flags(0) !== 5'b10000) begin
                    errors++;
                    $display("FAIL pkt_too_long: ch0=%b required 10000", flags(0));
                end
            end
        end
        checks++;
        if (in_packet[0] !== 1'b1) begin
            errors++;
            $display("FAIL pkt_in_packet_mid: got %b required 1", in_packet[0]);
        end
        drive(0, 1'b1, 1'b1, 32'h0000_01FF, 4'hF, 4'hF, 1'b1);
        step();
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);
        checks++;
        if (in_packet[0] !== 1'b0 || pkts(0) !== 8'd1 || beats(0) !== 8'd7) begin
            errors++;
            $display("FAIL pkt_end: inpkt=%b pkts=%0d beats=%0d required 0 1 7",
                     in_packet[0], pkts(0), beats(0));
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        drive(0, 1'b1, 1'b1, 32'h0000_0AA1, 4'hF, 4'hF, 1'b0);
        step();
        drive(0, 1'b1, 1'b1, 32'h0000_0AA2, 4'hF, 4'hF, 1'b0);
        step();
        drive(0, 1'b1, 1'b0, 32'h1111_1111, 4'hF, 4'hF, 1'b0);
        drive(1, 1'b1, 1'b1, 32'h0, 4'b0011, 4'b0001, 1'b1);
        step();
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);
        step();
        step();
        checks++;
        if (in_packet[0] !== 1'b1 || beats(0) !== 8'd2 || flags(1) !== 5'b00100 || err_any !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: inpkt=%b beats=%0d ch1=%b any=%b required 1 2 00100 1",
                     in_packet[0], beats(0), flags(1), err_any);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (err_flags !== '0 || err_any !== 1'b0 || in_packet !== '0 ||
            beat_count !== '0 || pkt_count !== '0) begin
            errors++;
            $display("FAIL async_reset: flags=%h any=%b inpkt=%b beats=%h pkts=%h, required all 0",
                     err_flags, err_any, in_packet, beat_count, pkt_count);
        end
        drive(0, 1'b1, 1'b0, 32'h2222_2222, 4'hF, 4'hF, 1'b1);
        step();
        reset = 1'b0;
        step();
        drive(0, 1'b1, 1'b1, 32'h2222_2222, 4'hF, 4'hF, 1'b1);
        step();
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);
        step();
        checks++;
        if (err_flags !== '0 || beats(0) !== 8'd1 || pkts(0) !== 8'd1) begin
            errors++;
            $display("FAIL post_reset_beat: flags=%h beats=%0d pkts=%0d required 0 1 1",
                     err_flags, beats(0), pkts(0));
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int b = 0; b < 9; b++) begin
            drive(0, 1'b1, 1'b1, 32'h0000_5000 + 32'(b), 4'hF, 4'hF, 1'b1);
            step();
        end
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);
        step();
        checks++;
        if (s_beat_count[0 +: SCW] !== 3'd7 || s_pkt_count[0 +: SCW] !== 3'd7) begin
            errors++;
            $display("FAIL saturation_3bit: beats=%0d pkts=%0d required 7 7",
                     s_beat_count[0 +: SCW], s_pkt_count[0 +: SCW]);
        end
        checks++;
        if (beats(0) !== 8'd9 || pkts(0) !== 8'd9) begin
            errors++;
            $display("FAIL count_8bit: beats=%0d pkts=%0d required 9 9", beats(0), pkts(0));
        end
    endtask

    initial begin
        test_reset();
        test_legal_traffic();
        test_valid_drop();
        test_payload_errors();
        test_stall_timeout();
        test_pkt_too_long();
        test_reset_mid_packet();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
